// File: rtl/fetch_pkg.sv
// Shared defaults for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned     DEF_INSN_WIDTH      = 32;
  localparam int unsigned     DEF_ADDR_WIDTH      = 32;
  localparam longint unsigned DEF_RESET_PC        = 0;
  localparam int unsigned     DEF_PC_STEP         = 4;
  localparam int unsigned     DEF_FETCH_BUF_DEPTH = 2;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO holding {pc, insn} returns that decode could not take yet.
module fetch_skid_buffer #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             head_q, head_d;
  logic [1:0]       count_q, count_d;
  logic             tail;
  logic             do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    count_d = count_q;
    tail    = head_q ^ count_q[0];
    do_push = push && (count_q != 2'd2);
    do_pop  = pop && (count_q != 2'd0);
    // Flush wins over push so a squashed return never lands in the buffer.
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (do_push) mem_d[tail] = push_data;
      if (do_pop) head_d = ~head_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

  a_count_range: assert property (@(posedge clk) disable iff (!rst) count_q != 2'd3);

endmodule

// File: rtl/fetch_controller.sv
// PC sequencer: one fetch per cycle into a 1-cycle-latency memory, with a
// zero-bubble bypass to decode and a skid buffer for back-pressure.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned           INSN_WIDTH = DEF_INSN_WIDTH,
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC),
  parameter int unsigned           PC_STEP    = DEF_PC_STEP,
  parameter int unsigned           BUF_DEPTH  = DEF_FETCH_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INSN_WIDTH-1:0] imem_insn,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [INSN_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] insn_pc
);

  localparam int unsigned ENTRY_W = ADDR_WIDTH + INSN_WIDTH;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  logic [ENTRY_W-1:0] buf_head;
  logic [1:0]         buf_count;
  logic               buf_push, buf_pop, bypass;
  logic               pop, issue;
  logic [2:0]         occ;

  // Decode handshake: insn/insn_pc are offered while insn_valid is high and
  // must hold until insn_ready is seen on a clock edge (valid && ready).
  always_comb begin
    insn_valid = (buf_count != 2'd0) || inflight_q;
    insn       = '0;
    insn_pc    = '0;
    if (buf_count != 2'd0) begin
      {insn_pc, insn} = buf_head;
    end else if (inflight_q) begin
      insn    = imem_insn;
      insn_pc = inflight_pc_q;
    end
  end

  // occ counts what will occupy the buffer if nothing new is issued.
  always_comb begin
    pop           = insn_valid && insn_ready;
    occ           = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
    issue         = redirect_valid || (fetch_en && (occ < 3'(BUF_DEPTH)));
    imem_addr     = redirect_valid ? redirect_pc : pc_q;
    pc_d          = issue ? imem_addr + ADDR_WIDTH'(PC_STEP) : pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? imem_addr : inflight_pc_q;
    bypass        = (buf_count == 2'd0);
    buf_push      = inflight_q && !redirect_valid && !(bypass && pop);
    buf_pop       = pop && !bypass;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_skid_buffer #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .push_data({inflight_pc_q, imem_insn}),
    .pop      (buf_pop),
    .flush    (redirect_valid),
    .head_data(buf_head),
    .count    (buf_count)
  );

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (insn_valid && !insn_ready && !redirect_valid) |=> ($stable(insn) && $stable(insn_pc)));

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus random traffic checked
// against an in-order PC stream model.
module tb_fetch_controller;

  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_insn;
  logic          insn_valid;
  logic          insn_ready = 1'b0;
  logic [IW-1:0] insn;
  logic [AW-1:0] insn_pc;

  logic [AW-1:0] mem_addr_q = '0;

  int            tests_run = 0;
  int            tests_failed = 0;
  int            n_xfer = 0;
  logic [AW-1:0] exp_pc = '0;
  logic          prev_hold = 1'b0;
  logic [IW-1:0] prev_insn = '0;
  logic [AW-1:0] prev_pc = '0;

  fetch_controller dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_insn     (imem_insn),
    .insn_valid    (insn_valid),
    .insn_ready    (insn_ready),
    .insn          (insn),
    .insn_pc       (insn_pc)
  );

  // Clock and memory model
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000_0000 + {2'b00, a[AW-1:2]};
  endfunction

  always @(posedge clk) mem_addr_q <= imem_addr;
  assign imem_insn = mem_word(mem_addr_q);

  // One clock of stimulus; checks transfers against the expected PC stream.
  task automatic cycle(input logic en, input logic rdy, input logic rv, input logic [AW-1:0] rpc);
    @(negedge clk);
    fetch_en       = en;
    insn_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (prev_hold) begin
      tests_run++;
      if (insn_valid !== 1'b1 || insn !== prev_insn || insn_pc !== prev_pc) begin
        tests_failed++;
        $display("FAIL hold_stable: got valid=%b pc=%h insn=%h, required valid=1 pc=%h insn=%h",
                 insn_valid, insn_pc, insn, prev_pc, prev_insn);
      end
    end
    if (insn_valid === 1'b1 && rdy) begin
      n_xfer++;
      tests_run++;
      if (insn_pc !== exp_pc || insn !== mem_word(exp_pc)) begin
        tests_failed++;
        $display("FAIL transfer_order: got pc=%h insn=%h, required pc=%h insn=%h",
                 insn_pc, insn, exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
    prev_hold = (insn_valid === 1'b1) && !rdy && !rv;
    prev_insn = insn;
    prev_pc   = insn_pc;
    if (rv) exp_pc = rpc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (insn_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b required 0", insn_valid); end
    tests_run++;
    if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h required 0", imem_addr); end
    tests_run++;
    if (insn !== 32'h0) begin tests_failed++; $display("FAIL reset_insn: got %h required 0", insn); end
    tests_run++;
    if (insn_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h required 0", insn_pc); end
    rst    = 1'b1;
    exp_pc = '0;
    cycle(1'b0, 1'b1, 1'b0, '0);
    tests_run++;
    if (insn_valid !== 1'b0 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got valid=%b addr=%h required valid=0 addr=0", insn_valid, imem_addr);
    end
  endtask

  task automatic test_stream();
    int base;
    base = n_xfer;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (n_xfer - base != 4) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d transfers required 4", n_xfer - base);
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] e;
    int base;
    e = exp_pc;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      tests_run++;
      if (insn_valid !== 1'b1 || insn_pc !== e) begin
        tests_failed++;
        $display("FAIL stall_head: got valid=%b pc=%h required valid=1 pc=%h", insn_valid, insn_pc, e);
      end
      if (i >= 2) begin
        tests_run++;
        if (imem_addr !== e + 32'd8) begin
          tests_failed++;
          $display("FAIL stall_addr: got %h required %h", imem_addr, e + 32'd8);
        end
      end
    end
    base = n_xfer;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (n_xfer - base != 4) begin
      tests_failed++;
      $display("FAIL stall_release: got %0d transfers required 4", n_xfer - base);
    end
  endtask

  task automatic test_redirect();
    int base;
    cycle(1'b1, 1'b0, 1'b1, 32'h200);
    base = n_xfer;
    cycle(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (imem_addr !== 32'h204 || insn_valid !== 1'b1 || insn_pc !== 32'h200) begin
      tests_failed++;
      $display("FAIL redirect_first: got addr=%h valid=%b pc=%h required addr=204 valid=1 pc=200",
               imem_addr, insn_valid, insn_pc);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (n_xfer - base != 5) begin
      tests_failed++;
      $display("FAIL redirect_stream: got %0d transfers required 5", n_xfer - base);
    end
  endtask

  task automatic test_redirect_stall();
    logic [AW-1:0] g;
    g = exp_pc;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0);
    tests_run++;
    if (imem_addr !== g + 32'd8) begin
      tests_failed++;
      $display("FAIL full_stall_addr: got %h required %h", imem_addr, g + 32'd8);
    end
    cycle(1'b1, 1'b0, 1'b1, 32'h300);
    cycle(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (insn_valid !== 1'b1 || insn_pc !== 32'h300 || imem_addr !== 32'h304) begin
      tests_failed++;
      $display("FAIL redirect_flush: got valid=%b pc=%h addr=%h required valid=1 pc=300 addr=304",
               insn_valid, insn_pc, imem_addr);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic test_fetch_en();
    logic [AW-1:0] e;
    int base;
    e    = exp_pc;
    base = n_xfer;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      tests_run++;
      if (imem_addr !== e + 32'd4) begin
        tests_failed++;
        $display("FAIL freeze_addr: got %h required %h", imem_addr, e + 32'd4);
      end
      if (i > 0) begin
        tests_run++;
        if (insn_valid !== 1'b0) begin tests_failed++; $display("FAIL freeze_valid: got %b required 0", insn_valid); end
      end
    end
    tests_run++;
    if (n_xfer - base != 1) begin
      tests_failed++;
      $display("FAIL freeze_drain: got %0d transfers required 1", n_xfer - base);
    end
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (insn_valid !== 1'b1 || insn_pc !== e + 32'd4) begin
      tests_failed++;
      $display("FAIL resume_pc: got valid=%b pc=%h required valid=1 pc=%h", insn_valid, insn_pc, e + 32'd4);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (exp_pc !== 32'h0000_000C) begin
      tests_failed++;
      $display("FAIL wrap_progress: got next pc %h required 0000000c", exp_pc);
    end
  endtask

  task automatic test_async_reset();
    int base;
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (insn_valid !== 1'b0 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got valid=%b addr=%h required valid=0 addr=0", insn_valid, imem_addr);
    end
    @(negedge clk);
    fetch_en = 1'b0;
    #1;
    rst       = 1'b1;
    prev_hold = 1'b0;
    exp_pc    = '0;
    base      = n_xfer;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (n_xfer - base != 5) begin
      tests_failed++;
      $display("FAIL restart_stream: got %0d transfers required 5", n_xfer - base);
    end
  endtask

  task automatic test_random();
    int base;
    logic en, rdy, rv;
    logic [AW-1:0] rpc;
    base = n_xfer;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom() & 32'hFFFF_FFFC;
      cycle(en, rdy, rv, rpc);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (n_xfer - base < 100) begin
      tests_failed++;
      $display("FAIL random_throughput: got %0d transfers required at least 100", n_xfer - base);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_fetch_en();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
